uart_rx_deframer: RTL and testbench

Consumes the de-bounced serial line from the UART receive filter and recovers characters.
- Detects the start bit and validates it at mid-bit.
- Samples data bits at mid-bit, LSB first, then checks optional parity and the stop bit.
- Presents each byte with a one-cycle strobe plus error flags to the downstream FIFO/register interface.
- Runs on the same oversample clock and enable as the filter.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_deframer.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   state_t         : receive deframer state enumeration
//   PAR_NONE/ODD/EVEN : parity mode selectors for the PARITY parameter
//   parityMismatch  : folds the XOR of data+parity bit into an error flag
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    BRK
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // xorAll is the XOR of every data bit and the received parity bit.
  // Odd parity expects that XOR to be 1, even parity expects 0.
  function automatic logic parityMismatch(input int mode, input logic xorAll);
    logic result;
    result = 1'b0;
    if (mode == PAR_ODD) begin
      result = ~xorAll;
    end else if (mode == PAR_EVEN) begin
      result = xorAll;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
// Recovers characters from the filtered UART receive line. A falling line seen
// on an oversample tick starts a frame; the start bit is re-checked at mid-bit,
// data bits are sampled LSB first at mid-bit, then optional parity and the stop
// bit. Each good character is presented with a single-cycle valid strobe; a
// bad stop bit produces a single-cycle frame_err strobe and the receiver then
// waits for the line to return high before looking for another start.
//
// Ports:
//   i_samp_clk    : sampling clock shared with the receive filter
//   i_reset       : asynchronous active-high reset
//   i_bit_clk     : oversample tick enable, one i_samp_clk cycle wide
//   i_rx          : filtered serial line, idle high
//   o_data        : last received character, held until the next valid
//   o_valid       : one-cycle strobe, o_data updated
//   o_parity_err  : parity mismatch, qualified by o_valid
//   o_frame_err   : one-cycle strobe, stop bit sampled low
//   o_busy        : high whenever a frame (or break) is in progress
// -----------------------------------------------------------------------------
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0
) (
  input  logic                 i_samp_clk,
  input  logic                 i_reset,
  input  logic                 i_bit_clk,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  state_t                 r_state;
  state_t                 w_nextState;
  logic [CW-1:0]          r_tickCnt;
  logic [BW-1:0]          r_bitCnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_parErr;
  logic                   r_parOut;
  logic                   r_valid;
  logic                   r_frameErr;
  logic                   w_startMid;
  logic                   w_bitMid;

  // Mid-bit sample points. The start bit is checked half a bit after the
  // falling edge; every later bit is one full bit after the previous sample.
  assign w_startMid = i_bit_clk && (r_state == START) && (r_tickCnt == HALF_LAST);
  assign w_bitMid   = i_bit_clk && ((r_state == DATA) || (r_state == PAR) || (r_state == STOP))
                      && (r_tickCnt == BIT_LAST);

  // State register.
  always_ff @(posedge i_samp_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Leaving STOP straight after its mid-bit sample gives
  // half a bit of margin to catch a back-to-back start edge.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (i_bit_clk && !i_rx) begin
          w_nextState = START;
        end
      end
      START: begin
        if (w_startMid) begin
          w_nextState = i_rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_bitMid && (r_bitCnt == DATA_LAST)) begin
          w_nextState = (PARITY != PAR_NONE) ? PAR : STOP;
        end
      end
      PAR: begin
        if (w_bitMid) begin
          w_nextState = STOP;
        end
      end
      STOP: begin
        if (w_bitMid) begin
          w_nextState = i_rx ? IDLE : BRK;
        end
      end
      BRK: begin
        if (i_bit_clk && i_rx) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Tick counter: cleared at every sample point and while idle or in break,
  // so it never needs to wrap.
  always_ff @(posedge i_samp_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tickCnt <= '0;
    end else if (i_bit_clk) begin
      if ((r_state == IDLE) || (r_state == BRK) || w_startMid || w_bitMid) begin
        r_tickCnt <= '0;
      end else begin
        r_tickCnt <= r_tickCnt + 1'b1;
      end
    end
  end

  // Bit counter: only meaningful in DATA, held at zero everywhere else.
  always_ff @(posedge i_samp_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bitCnt <= '0;
    end else if (i_bit_clk) begin
      if (r_state != DATA) begin
        r_bitCnt <= '0;
      end else if (w_bitMid) begin
        r_bitCnt <= r_bitCnt + 1'b1;
      end
    end
  end

  // Datapath. Strobes default low every samp_clk cycle so they stay one cycle
  // wide however far apart the oversample ticks are.
  always_ff @(posedge i_samp_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift    <= '0;
      r_data     <= '0;
      r_parErr   <= 1'b0;
      r_parOut   <= 1'b0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      r_parOut   <= 1'b0;
      if (w_startMid && !i_rx) begin
        r_parErr <= 1'b0;
      end
      if ((r_state == DATA) && w_bitMid) begin
        r_shift <= {i_rx, r_shift[DATA_BITS-1:1]};
      end
      if ((r_state == PAR) && w_bitMid) begin
        r_parErr <= parityMismatch(PARITY, (^r_shift) ^ i_rx);
      end
      if ((r_state == STOP) && w_bitMid) begin
        if (i_rx) begin
          r_valid  <= 1'b1;
          r_data   <= r_shift;
          r_parOut <= r_parErr;
        end else begin
          r_frameErr <= 1'b1;
        end
      end
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_parity_err = r_parOut;
  assign o_frame_err  = r_frameErr;
  assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deframer
// Drives two deframers from one clock: uA is 8N1, uB is 8E1. Frames are built
// bit by bit from the character, expected results come from the frame layout
// and a ones-count parity rule, and a monitor records every strobe with the
// oversample tick index on which it appeared.
// -----------------------------------------------------------------------------
module tb_uart_rx_deframer;

  localparam int OS = 16;
  localparam int DB = 8;

  logic       samp_clk = 1'b0;
  logic       reset;
  logic       bit_clk;
  logic       rxA;
  logic       rxB;
  logic [7:0] dataA;
  logic [7:0] dataB;
  logic       validA, parA, feA, busyA;
  logic       validB, parB, feB, busyB;

  int   total = 0;
  int   bad = 0;
  int   tickNum = 0;
  bit   tieHigh = 1'b0;
  int   divCnt = 0;
  int   busyFallA = -1;
  logic prevBusyA = 1'b0;
  int   qualViol = 0;

  int vDataA[$];
  int vParA[$];
  int vTickA[$];
  int feTickA[$];
  int vDataB[$];
  int vParB[$];
  int vTickB[$];
  int feTickB[$];

  uart_rx_deframer #(.OVERSAMPLE(OS), .DATA_BITS(DB), .PARITY(0)) uA (
    .i_samp_clk  (samp_clk),
    .i_reset     (reset),
    .i_bit_clk   (bit_clk),
    .i_rx        (rxA),
    .o_data      (dataA),
    .o_valid     (validA),
    .o_parity_err(parA),
    .o_frame_err (feA),
    .o_busy      (busyA)
  );

  uart_rx_deframer #(.OVERSAMPLE(OS), .DATA_BITS(DB), .PARITY(2)) uB (
    .i_samp_clk  (samp_clk),
    .i_reset     (reset),
    .i_bit_clk   (bit_clk),
    .i_rx        (rxB),
    .o_data      (dataB),
    .o_valid     (validB),
    .o_parity_err(parB),
    .o_frame_err (feB),
    .o_busy      (busyB)
  );

  always #5 samp_clk = ~samp_clk;

  // Oversample tick: every 4th cycle, or every cycle when tieHigh is set.
  initial begin
    bit_clk = 1'b0;
    forever begin
      @(negedge samp_clk);
      divCnt = (divCnt + 1) % 4;
      bit_clk = tieHigh || (divCnt == 0);
    end
  end

  // Monitor: tick index and strobe capture, sampled just after each edge.
  always @(posedge samp_clk) begin
    #1;
    if (bit_clk) tickNum++;
    if (validA) begin
      vDataA.push_back(int'(dataA));
      vParA.push_back(int'(parA));
      vTickA.push_back(tickNum);
    end
    if (feA) feTickA.push_back(tickNum);
    if (validB) begin
      vDataB.push_back(int'(dataB));
      vParB.push_back(int'(parB));
      vTickB.push_back(tickNum);
    end
    if (feB) feTickB.push_back(tickNum);
    if ((parA && !validA) || (parB && !validB) || (validA && feA) || (validB && feB)) qualViol++;
    if (prevBusyA && !busyA) busyFallA = tickNum;
    prevBusyA = busyA;
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic holdTicks(input int n);
    repeat (n) begin
      @(posedge samp_clk);
      while (!bit_clk) @(posedge samp_clk);
    end
    @(negedge samp_clk);
  endtask

  task automatic setRx(input int sel, input logic v);
    if (sel == 0) rxA = v;
    else rxB = v;
  endtask

  // Sends one frame on DUT sel (0 = 8N1, 1 = 8E1); t0 is the tick index on
  // which the receiver first sees the start bit.
  task automatic applyStimulus(input int sel, input logic [7:0] dat, input logic parBit,
                               input logic stopBit, output int t0);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(dat[i]);
    if (sel == 1) bits.push_back(parBit);
    bits.push_back(stopBit);
    t0 = tickNum + 1;
    foreach (bits[i]) begin
      setRx(sel, bits[i]);
      holdTicks(OS);
    end
  endtask

  task automatic expectFrame(input int sel, input logic [7:0] dat, input logic parBit,
                             input int t0, input string tag);
    int   nBits;
    int   expTick;
    logic expPar;
    int   cnt;
    int   d, p, t;
    nBits   = 1 + DB + ((sel == 1) ? 1 : 0);
    expTick = t0 + OS / 2 + nBits * OS;
    expPar  = (sel == 1) ? ((($countones(dat) + int'(parBit)) % 2) != 0) : 1'b0;
    cnt     = (sel == 0) ? vDataA.size() : vDataB.size();
    checkOutput({tag, "_cnt"}, (cnt > 0) ? 1 : 0, 1);
    if (cnt > 0) begin
      if (sel == 0) begin
        d = vDataA.pop_front(); p = vParA.pop_front(); t = vTickA.pop_front();
      end else begin
        d = vDataB.pop_front(); p = vParB.pop_front(); t = vTickB.pop_front();
      end
      checkOutput({tag, "_data"}, d, int'(dat));
      checkOutput({tag, "_par"}, p, int'(expPar));
      checkOutput({tag, "_tick"}, t, expTick);
    end
  endtask

  initial begin
    int         t0, t0b;
    logic [7:0] d;
    logic       pb;

    reset = 1'b1;
    rxA = 1'b1;
    rxB = 1'b1;
    repeat (3) @(negedge samp_clk);
    checkOutput("rst_dataA", dataA, 0);
    checkOutput("rst_validA", validA, 0);
    checkOutput("rst_parA", parA, 0);
    checkOutput("rst_feA", feA, 0);
    checkOutput("rst_busyA", busyA, 0);
    checkOutput("rst_dataB", dataB, 0);
    checkOutput("rst_busyB", busyB, 0);
    reset = 1'b0;
    holdTicks(5);

    // Basic 8N1 character and its latency.
    applyStimulus(0, 8'hA5, 1'b0, 1'b1, t0);
    holdTicks(2);
    expectFrame(0, 8'hA5, 1'b0, t0, "a5");
    checkOutput("a5_dout", dataA, 8'hA5);
    checkOutput("a5_fe", feTickA.size(), 0);
    checkOutput("a5_busy", busyA, 0);

    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      applyStimulus(0, d, 1'b0, 1'b1, t0);
      holdTicks(1);
      expectFrame(0, d, 1'b0, t0, "rnd8n1");
      checkOutput("rnd8n1_dout", dataA, d);
    end

    // Short low glitch is a false start.
    busyFallA = -1;
    setRx(0, 1'b0);
    t0 = tickNum + 1;
    holdTicks(4);
    setRx(0, 1'b1);
    holdTicks(12);
    checkOutput("glitch_busyFall", busyFallA, t0 + OS / 2);
    checkOutput("glitch_valid", vDataA.size(), 0);
    checkOutput("glitch_fe", feTickA.size(), 0);
    applyStimulus(0, 8'h3C, 1'b0, 1'b1, t0);
    holdTicks(1);
    expectFrame(0, 8'h3C, 1'b0, t0, "g3c");

    // Bad stop bit followed by a long break.
    d = 8'($urandom_range(0, 255));
    applyStimulus(0, d, 1'b0, 1'b0, t0);
    holdTicks(40);
    setRx(0, 1'b1);
    holdTicks(20);
    checkOutput("brk_feCnt", feTickA.size(), 1);
    checkOutput("brk_feTick", (feTickA.size() > 0) ? feTickA[0] : -1, t0 + OS / 2 + (DB + 1) * OS);
    checkOutput("brk_valid", vDataA.size(), 0);
    checkOutput("brk_dataHeld", dataA, 8'h3C);
    checkOutput("brk_busy", busyA, 0);
    feTickA.delete();
    d = 8'($urandom_range(0, 255));
    applyStimulus(0, d, 1'b0, 1'b1, t0);
    holdTicks(1);
    expectFrame(0, d, 1'b0, t0, "postbrk");

    // Even parity receiver.
    applyStimulus(1, 8'h03, 1'b1, 1'b1, t0);
    holdTicks(1);
    expectFrame(1, 8'h03, 1'b1, t0, "p03bad");
    applyStimulus(1, 8'h03, 1'b0, 1'b1, t0);
    holdTicks(1);
    expectFrame(1, 8'h03, 1'b0, t0, "p03ok");
    for (int i = 0; i < 4; i++) begin
      d  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      applyStimulus(1, d, pb, 1'b1, t0);
      holdTicks(1);
      expectFrame(1, d, pb, t0, "rndpar");
    end
    checkOutput("par_fe", feTickB.size(), 0);

    // Reset in the middle of a frame.
    applyStimulus(0, 8'hC3, 1'b0, 1'b1, t0);
    holdTicks(1);
    expectFrame(0, 8'hC3, 1'b0, t0, "c3");
    setRx(0, 1'b0);
    holdTicks(60);
    @(posedge samp_clk);
    while (!bit_clk) @(posedge samp_clk);
    #2;
    checkOutput("midrst_busyBefore", busyA, 1);
    reset = 1'b1;
    #1;
    checkOutput("midrst_data", dataA, 0);
    checkOutput("midrst_valid", validA, 0);
    checkOutput("midrst_par", parA, 0);
    checkOutput("midrst_fe", feA, 0);
    checkOutput("midrst_busy", busyA, 0);
    @(negedge samp_clk);
    reset = 1'b0;
    setRx(0, 1'b1);
    holdTicks(20);
    checkOutput("midrst_noValid", vDataA.size(), 0);
    checkOutput("midrst_noFe", feTickA.size(), 0);
    applyStimulus(0, 8'h5A, 1'b0, 1'b1, t0);
    holdTicks(1);
    expectFrame(0, 8'h5A, 1'b0, t0, "r5a");

    // Back-to-back frames with a tick every cycle.
    tieHigh = 1'b1;
    holdTicks(5);
    applyStimulus(0, 8'h11, 1'b0, 1'b1, t0);
    applyStimulus(0, 8'hEE, 1'b0, 1'b1, t0b);
    holdTicks(2);
    expectFrame(0, 8'h11, 1'b0, t0, "b2b11");
    expectFrame(0, 8'hEE, 1'b0, t0b, "b2bEE");
    checkOutput("b2b_dout", dataA, 8'hEE);
    checkOutput("b2b_fe", feTickA.size(), 0);

    checkOutput("qualify", qualViol, 0);
    checkOutput("leftoverA", vDataA.size(), 0);
    checkOutput("leftoverB", vDataB.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
